quant_zigzag_ctrl: RTL and testbench

QUANT_ZIGZAG_CTRL -- requirements
Module: quant_zigzag_ctrl

---
 rtl/quant_zigzag_ctrl.sv | 160 ++++++++++++++++
 tb/tb_quant_zigzag_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/quant_zigzag_ctrl.sv
// Quantizer handshake and zigzag serializer: latches a DCT block, lets the external
// quantizer settle, captures its result and streams the 64 coefficients in JPEG zigzag order.
module quant_zigzag_ctrl #(
  parameter int unsigned BLOCK_SIZE    = 8,
  parameter int unsigned DCT_OUT_WIDTH = 52
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                blk_valid,
  output logic                                                blk_ready,
  input  logic [BLOCK_SIZE*BLOCK_SIZE*DCT_OUT_WIDTH-1:0]      blk_data,
  output logic [BLOCK_SIZE*BLOCK_SIZE*DCT_OUT_WIDTH-1:0]      q_in,
  input  logic [BLOCK_SIZE*BLOCK_SIZE*DCT_OUT_WIDTH-1:0]      q_out,
  output logic                                                coef_valid,
  input  logic                                                coef_ready,
  output logic signed [DCT_OUT_WIDTH-1:0]                     coef_data,
  output logic [5:0]                                          coef_idx,
  output logic                                                coef_last,
  output logic                                                blk_done,
  output logic [6:0]                                          last_nz
);

  localparam int unsigned NUM_COEF = BLOCK_SIZE * BLOCK_SIZE;
  localparam int unsigned W        = DCT_OUT_WIDTH;
  localparam logic [5:0]  LAST_IDX = 6'd63;
  localparam logic [6:0]  NONE_NZ  = 7'd64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CAPT   = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state;
  state_t state_d;

  logic                blk_ready_q;
  logic [5:0]          k;
  logic signed [W-1:0] buffer [NUM_COEF];

  logic                blk_ready_d;
  logic                coef_valid_d;
  logic                blk_done_d;
  logic                coef_last_d;
  logic [5:0]          k_d;
  logic signed [W-1:0] coef_data_d;
  logic [6:0]          last_nz_d;
  logic                xfer;
  logic                accept;
  logic                capture;

  // Zigzag scan position k -> raster address row*8+col
  function automatic logic [5:0] zz_addr(input logic [5:0] idx);
    zz_addr = 6'd0;
    case (idx)
      6'd0:  zz_addr = 6'd0;   6'd1:  zz_addr = 6'd1;   6'd2:  zz_addr = 6'd8;   6'd3:  zz_addr = 6'd16;
      6'd4:  zz_addr = 6'd9;   6'd5:  zz_addr = 6'd2;   6'd6:  zz_addr = 6'd3;   6'd7:  zz_addr = 6'd10;
      6'd8:  zz_addr = 6'd17;  6'd9:  zz_addr = 6'd24;  6'd10: zz_addr = 6'd32;  6'd11: zz_addr = 6'd25;
      6'd12: zz_addr = 6'd18;  6'd13: zz_addr = 6'd11;  6'd14: zz_addr = 6'd4;   6'd15: zz_addr = 6'd5;
      6'd16: zz_addr = 6'd12;  6'd17: zz_addr = 6'd19;  6'd18: zz_addr = 6'd26;  6'd19: zz_addr = 6'd33;
      6'd20: zz_addr = 6'd40;  6'd21: zz_addr = 6'd48;  6'd22: zz_addr = 6'd41;  6'd23: zz_addr = 6'd34;
      6'd24: zz_addr = 6'd27;  6'd25: zz_addr = 6'd20;  6'd26: zz_addr = 6'd13;  6'd27: zz_addr = 6'd6;
      6'd28: zz_addr = 6'd7;   6'd29: zz_addr = 6'd14;  6'd30: zz_addr = 6'd21;  6'd31: zz_addr = 6'd28;
      6'd32: zz_addr = 6'd35;  6'd33: zz_addr = 6'd42;  6'd34: zz_addr = 6'd49;  6'd35: zz_addr = 6'd56;
      6'd36: zz_addr = 6'd57;  6'd37: zz_addr = 6'd50;  6'd38: zz_addr = 6'd43;  6'd39: zz_addr = 6'd36;
      6'd40: zz_addr = 6'd29;  6'd41: zz_addr = 6'd22;  6'd42: zz_addr = 6'd15;  6'd43: zz_addr = 6'd23;
      6'd44: zz_addr = 6'd30;  6'd45: zz_addr = 6'd37;  6'd46: zz_addr = 6'd44;  6'd47: zz_addr = 6'd51;
      6'd48: zz_addr = 6'd58;  6'd49: zz_addr = 6'd59;  6'd50: zz_addr = 6'd52;  6'd51: zz_addr = 6'd45;
      6'd52: zz_addr = 6'd38;  6'd53: zz_addr = 6'd31;  6'd54: zz_addr = 6'd39;  6'd55: zz_addr = 6'd46;
      6'd56: zz_addr = 6'd53;  6'd57: zz_addr = 6'd60;  6'd58: zz_addr = 6'd61;  6'd59: zz_addr = 6'd54;
      6'd60: zz_addr = 6'd47;  6'd61: zz_addr = 6'd55;  6'd62: zz_addr = 6'd62;  6'd63: zz_addr = 6'd63;
      default: zz_addr = 6'd0;
    endcase
  endfunction

  // blk_ready must fall in the same cycle rst is raised, so it is gated outside the flop
  assign blk_ready = blk_ready_q & ~rst;

  assign xfer    = coef_valid & coef_ready;
  assign accept  = (state == IDLE) & blk_valid;
  assign capture = (state == CAPT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = CAPT;
      CAPT:    state_d = STREAM;
      STREAM:  if (xfer && (k == LAST_IDX)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered handshake/stream outputs
  always_comb begin
    blk_ready_d  = (state_d == IDLE);
    coef_valid_d = (state_d == STREAM);
    blk_done_d   = (state_d == DONE);
    k_d          = k;
    coef_data_d  = coef_data;
    last_nz_d    = last_nz;

    if (capture) begin
      k_d         = 6'd0;
      // zigzag position 0 is raster address 0; taken straight from q_out since buffer loads this edge
      coef_data_d = $signed(q_out[W-1:0]);
      last_nz_d   = NONE_NZ;
    end else if (xfer) begin
      k_d = k + 6'd1;
      if (k != LAST_IDX) coef_data_d = buffer[zz_addr(k_d)];
      if (coef_data != '0) last_nz_d = {1'b0, k};
    end

    coef_last_d = (state_d == STREAM) && (k_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_ready_q <= 1'b1;
      coef_valid  <= 1'b0;
      blk_done    <= 1'b0;
      coef_last   <= 1'b0;
      k           <= 6'd0;
      coef_data   <= '0;
      last_nz     <= NONE_NZ;
    end else begin
      blk_ready_q <= blk_ready_d;
      coef_valid  <= coef_valid_d;
      blk_done    <= blk_done_d;
      coef_last   <= coef_last_d;
      k           <= k_d;
      coef_data   <= coef_data_d;
      last_nz     <= last_nz_d;
    end
  end

  assign coef_idx = k;

  // Block datapath: input latch and captured quantizer result
  always_ff @(posedge clk) begin
    if (rst) begin
      q_in <= '0;
      for (int unsigned i = 0; i < NUM_COEF; i++) buffer[i] <= '0;
    end else begin
      if (accept) q_in <= blk_data;
      if (capture) begin
        for (int unsigned i = 0; i < NUM_COEF; i++) buffer[i] <= $signed(q_out[i*W +: W]);
      end
    end
  end

endmodule

// File: tb/tb_quant_zigzag_ctrl.sv
// Directed bench for quant_zigzag_ctrl: latency, zigzag order, backpressure,
// last-nonzero tracking, mid-stream reset and continuous blk_valid.
module tb_quant_zigzag_ctrl;

  localparam int DW = 52;
  localparam int N  = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 blk_valid;
  logic                 blk_ready;
  logic [N*DW-1:0]      blk_data;
  logic [N*DW-1:0]      q_in;
  logic [N*DW-1:0]      q_out;
  logic                 coef_valid;
  logic                 coef_ready;
  logic signed [DW-1:0] coef_data;
  logic [5:0]           coef_idx;
  logic                 coef_last;
  logic                 blk_done;
  logic [6:0]           last_nz;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int qmode  = 0;

  logic [N*DW-1:0]      ramp;
  logic [N*DW-1:0]      flat7;
  logic signed [DW-1:0] exp_coef [N];

  int zz_tb [N] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
                    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
                    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  quant_zigzag_ctrl #(.BLOCK_SIZE(8), .DCT_OUT_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .q_in(q_in), .q_out(q_out),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .coef_idx(coef_idx), .coef_last(coef_last),
    .blk_done(blk_done), .last_nz(last_nz)
  );

  always #5 clk = ~clk;

  // Quantizer model: 0 negate, 1 sparse (0,0)=5 and (2,0)=-3, otherwise all zero
  always_comb begin
    q_out = '0;
    if (qmode == 0) begin
      for (int i = 0; i < N; i++) q_out[i*DW +: DW] = -q_in[i*DW +: DW];
    end else if (qmode == 1) begin
      q_out[0 +: DW]     = DW'(5);
      q_out[16*DW +: DW] = DW'(-3);
    end
  end

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_ramp();
    for (int k = 0; k < N; k++) exp_coef[k] = DW'(-(zz_tb[k] + 1));
  endtask

  task automatic exp_const(input int v);
    for (int k = 0; k < N; k++) exp_coef[k] = DW'(v);
  endtask

  // Starts at a negedge with blk_ready=1; accepts one block and checks its whole stream
  task automatic run_block(input logic [N*DW-1:0] data, input int rdy_mode, input int exp_lnz,
                           input bit keep_valid, input logic [N*DW-1:0] alt_data);
    int cyc;
    int c;
    int idx;
    bit r;
    chk("accept_ready", 64'(blk_ready), 64'd1);
    blk_data   = data;
    blk_valid  = 1'b1;
    coef_ready = 1'b0;
    @(negedge clk); cyc = 1;
    if (keep_valid) blk_data = alt_data;
    else            blk_valid = 1'b0;
    chk("load_ready", 64'(blk_ready), 64'd0);
    chk("q_in_latched", 64'(q_in == data), 64'd1);
    chk("load_valid", 64'(coef_valid), 64'd0);
    @(negedge clk); cyc++;
    chk("capt_valid", 64'(coef_valid), 64'd0);
    @(negedge clk); cyc++;
    chk("latency_t3", 64'(coef_valid), 64'd1);
    idx = 0;
    c   = 0;
    while (idx < N && c < 400) begin
      chk("coef_valid", 64'(coef_valid), 64'd1);
      chk("coef_idx", 64'(coef_idx), 64'(idx));
      chk("coef_data", 64'(coef_data), 64'(exp_coef[idx]));
      chk("coef_last", 64'(coef_last), 64'(idx == 63));
      chk("done_early", 64'(blk_done), 64'd0);
      chk("ready_busy", 64'(blk_ready), 64'd0);
      chk("q_in_hold", 64'(q_in == data), 64'd1);
      r = (rdy_mode == 0) ? 1'b1 : ((c % 4) == 0 || (c % 4) == 3);
      coef_ready = r;
      if (r) idx++;
      c++;
      @(negedge clk); cyc++;
    end
    coef_ready = 1'b0;
    chk("stream_count", 64'(idx), 64'd64);
    chk("valid_drop", 64'(coef_valid), 64'd0);
    chk("blk_done", 64'(blk_done), 64'd1);
    chk("last_nz", 64'(last_nz), 64'(exp_lnz));
    if (rdy_mode == 0) chk("done_t67", 64'(cyc), 64'd67);
    @(negedge clk); cyc++;
    chk("done_pulse", 64'(blk_done), 64'd0);
    chk("ready_back", 64'(blk_ready), 64'd1);
    chk("last_nz_hold", 64'(last_nz), 64'(exp_lnz));
    if (rdy_mode == 0) chk("ready_t68", 64'(cyc), 64'd68);
  endtask

  initial begin
    int c;
    for (int i = 0; i < N; i++) begin
      ramp[i*DW +: DW]  = DW'(i + 1);
      flat7[i*DW +: DW] = DW'(7);
    end
    rst        = 1'b1;
    blk_valid  = 1'b0;
    blk_data   = '0;
    coef_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(blk_ready), 64'd0);
    chk("rst_valid", 64'(coef_valid), 64'd0);
    chk("rst_done", 64'(blk_done), 64'd0);
    chk("rst_last_nz", 64'(last_nz), 64'd64);
    chk("rst_idx", 64'(coef_idx), 64'd0);
    chk("rst_last", 64'(coef_last), 64'd0);
    chk("rst_data", 64'(coef_data), 64'd0);
    chk("rst_q_in", 64'(q_in == '0), 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 64'(blk_ready), 64'd1);
    @(negedge clk);

    // Single block, negating quantizer, coef_ready=1
    qmode = 0;
    exp_ramp();
    run_block(ramp, 0, 63, 1'b0, '0);

    // Backpressure 1,0,0,1
    run_block(ramp, 1, 63, 1'b0, '0);

    // Sparse block, then all-zero block
    qmode = 1;
    exp_const(0);
    exp_coef[0] = DW'(5);
    exp_coef[3] = DW'(-3);
    run_block(ramp, 0, 3, 1'b0, '0);
    qmode = 2;
    exp_const(0);
    run_block(ramp, 0, 64, 1'b0, '0);

    // Reset mid-stream at k=20
    qmode = 0;
    exp_ramp();
    blk_data   = ramp;
    blk_valid  = 1'b1;
    coef_ready = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    c = 0;
    while (!(coef_valid && coef_idx == 6'd20) && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("rs_reach_k20", 64'(coef_idx), 64'd20);
    rst = 1'b1;
    @(negedge clk);
    chk("rs_valid", 64'(coef_valid), 64'd0);
    chk("rs_done", 64'(blk_done), 64'd0);
    chk("rs_last_nz", 64'(last_nz), 64'd64);
    chk("rs_idx", 64'(coef_idx), 64'd0);
    chk("rs_ready_in_rst", 64'(blk_ready), 64'd0);
    rst = 1'b0;
    coef_ready = 1'b0;
    #1;
    chk("rs_ready", 64'(blk_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rs_no_done", 64'(blk_done), 64'd0);
      chk("rs_no_valid", 64'(coef_valid), 64'd0);
    end
    run_block(ramp, 0, 63, 1'b0, '0);

    // blk_valid held high; data changed mid-stream, second block accepted at T+68
    exp_ramp();
    run_block(ramp, 0, 63, 1'b1, flat7);
    exp_const(-7);
    run_block(flat7, 0, 63, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
